fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Drives the instruction-memory address and delivers the Inst/PCPlus4 pair that the decode stage consumes.
- Consumes the decode stage's branch resolution (Equal, branch target, branch control), the hazard unit's Pipe_stall and the control unit's UndefInst.
- Redirects the PC for taken branches and undefined-instruction traps, and flushes the wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on an undefined-instruction trap.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on a flush or reset.
- CNT_WIDTH, 16, width of the saturating stall/flush performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  instruction-memory address; equals the PC register.
- imem_data  in  32  instruction word; combinational read of imem_addr, valid in the same cycle.
- Pipe_stall  in  1  hazard stall; hold PC and IF/ID.
- BranchCtl  in  2  branch type of the instruction in ID: 01 = beq, 10 = bne, 00/11 = no branch.
- Equal  in  1  ID-stage operand compare result (after forwarding).
- PCPlus4PlusOff  in  32  branch target computed in ID.
- UndefInst  in  1  instruction in ID is undefined.
- Inst  out  32  IF/ID instruction register.
- PCPlus4  out  32  IF/ID PC+4 register.
- ifid_valid  out  1  IF/ID holds a real fetched instruction, not an inserted NOP.
- EPC  out  32  PC of the trapping instruction, computed as PCPlus4 - 4 at trap time.
- StallCount  out  CNT_WIDTH  cycles with an effective stall.
- FlushCount  out  CNT_WIDTH  flushes (branch taken or trap).

Behaviour:
- All state updates on the rising edge of clk only. Inst, PCPlus4 and ifid_valid are registered outputs; imem_addr is the PC register.
- Reset when rst=1 at the edge, overriding all other inputs:
  - PC = RESET_PC; Inst = NOP_INST; PCPlus4 = 0; ifid_valid = 0; EPC = 0; both counters = 0.
  - Reset asserted mid-stall or mid-redirect discards all pending state.
- taken = (BranchCtl==01 && Equal) || (BranchCtl==10 && !Equal). Branch delay slot: none; the wrong-path fetch is squashed.
- Per-cycle priority, highest first; exactly one case applies:
  1. trap (UndefInst=1 and ifid_valid=1): EPC <= PCPlus4 - 32'd4; PC <= EXC_VECTOR; Inst <= NOP_INST; ifid_valid <= 0; FlushCount++. Applies even when Pipe_stall=1.
  2. stall (Pipe_stall=1): PC, Inst, PCPlus4 and ifid_valid hold; StallCount++. A branch in ID is not resolved in this cycle; it resolves once the stall drops.
  3. branch (taken=1): PC <= PCPlus4PlusOff; Inst <= NOP_INST; PCPlus4 <= imem_addr + 4; ifid_valid <= 0; FlushCount++.
  4. normal: Inst <= imem_data; PCPlus4 <= imem_addr + 4; PC <= imem_addr + 4; ifid_valid <= 1.
- UndefInst with ifid_valid=0 is ignored. This covers the NOP bubble and the all-zero reset word.
- Arithmetic: PC + 4 and the EPC subtraction are modulo 2^32. PC 32'hFFFF_FFFC wraps to 0 without a flag.
- Counters saturate at all-ones and do not wrap.
- No alignment check; imem_addr[1:0] passes through as computed.
- Fetch-to-decode latency: 1 cycle (word at address A appears on Inst the edge after imem_addr=A). Branch penalty: 1 bubble. Trap penalty: 1 bubble.

Test Plan:
- Reset then free run, imem_data = 32'h2000_0000|addr: after rst drops, imem_addr = 0, 4, 8 on successive cycles. Inst lags by one cycle; PCPlus4 = 4, 8, 12; ifid_valid rises 1 cycle after reset release.
- Stall: Pipe_stall=1 for 3 cycles at PC=8. Required: imem_addr stays 8, Inst/PCPlus4 hold, StallCount = 3, fetch resumes at 8 then 12.
- beq taken: BranchCtl=01, Equal=1, PCPlus4PlusOff=32'h40 while PC=12. Required: next imem_addr = 32'h40, Inst = 0, ifid_valid = 0, FlushCount = 1. Also check beq with Equal=0, which falls through to 16.
- bne with Pipe_stall=1 and Equal=0 for 2 cycles, then stall drops. Required: no redirect during the stall; redirect on the first unstalled cycle.
- Trap: UndefInst=1, ifid_valid=1, PCPlus4=32'h24, Pipe_stall=1. Required: EPC = 32'h20, imem_addr = 32'h80, Inst = NOP. Also check UndefInst with ifid_valid=0, which causes no effect.
- Wrap and saturation: PC = 32'hFFFF_FFFC, then next imem_addr = 0. Hold Pipe_stall for 2^16+5 cycles; StallCount = 16'hFFFF. Assert rst mid-stall; all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the 5-stage
//   MIPS pipeline. The PC register drives the instruction memory directly.
//   The instruction returned in the same cycle is captured into IF/ID
//   together with PC+4.
//
//   The PC is redirected in two cases: to the branch target for a taken
//   beq/bne that is resolved in ID, and to EXC_VECTOR for an
//   undefined-instruction trap. In both cases the wrong-path fetch is
//   replaced by NOP_INST. There is no branch delay slot.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_addr       instruction-memory address (the PC register)
//   imem_data       instruction word for imem_addr, same cycle
//   Pipe_stall      hazard stall: hold PC and IF/ID
//   BranchCtl       01 = beq, 10 = bne, 00/11 = no branch
//   Equal           ID operand compare result
//   PCPlus4PlusOff  branch target computed in ID
//   UndefInst       instruction in ID is undefined
//   Inst, PCPlus4   IF/ID register contents
//   ifid_valid      IF/ID holds a real fetched instruction
//   EPC             PC of the last trapping instruction
//   StallCount      saturating count of stalled cycles
//   FlushCount      saturating count of flushes (taken branch or trap)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_data,
  input  logic                 Pipe_stall,
  input  logic [1:0]           BranchCtl,
  input  logic                 Equal,
  input  logic [31:0]          PCPlus4PlusOff,
  input  logic                 UndefInst,
  output logic [31:0]          Inst,
  output logic [31:0]          PCPlus4,
  output logic                 ifid_valid,
  output logic [31:0]          EPC,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  // IF/ID qualifier semantics: ifid_valid=1 means Inst/PCPlus4 describe a
  // real fetched instruction that decode may act on. ifid_valid=0 marks an
  // inserted bubble (reset or flush). Decode never receives backpressure
  // through this register. Pipe_stall simply freezes both the register and
  // its qualifier.

  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        taken;
  logic        trap;

  assign imem_addr = pc;

  // Sequential PC increment. The addition wraps modulo 2^32 by construction.
  assign pcNext = pc + 32'd4;

  // Branch resolution for the instruction in ID.
  always_comb begin
    taken = 1'b0;
    case (BranchCtl)
      2'b01:   taken = Equal;
      2'b10:   taken = ~Equal;
      default: taken = 1'b0;
    endcase
  end

  // An undefined opcode only traps if it belongs to a real instruction.
  // Bubbles and the all-zero reset word never trap.
  assign trap = UndefInst & ifid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      Inst       <= NOP_INST;
      PCPlus4    <= 32'd0;
      ifid_valid <= 1'b0;
      EPC        <= 32'd0;
      StallCount <= '0;
      FlushCount <= '0;
    end else if (trap) begin
      // The trap wins over a stall. The trapping instruction leaves the
      // pipe, so there is nothing left for the stall to protect.
      // PCPlus4 keeps its old value.
      EPC        <= PCPlus4 - 32'd4;
      pc         <= EXC_VECTOR;
      Inst       <= NOP_INST;
      ifid_valid <= 1'b0;
      if (FlushCount != '1) FlushCount <= FlushCount + CNT_WIDTH'(1);
    end else if (Pipe_stall) begin
      // Everything holds. A branch waiting in ID resolves once the stall
      // drops, because its operands may still be in flight.
      if (StallCount != '1) StallCount <= StallCount + CNT_WIDTH'(1);
    end else if (taken) begin
      pc         <= PCPlus4PlusOff;
      Inst       <= NOP_INST;
      PCPlus4    <= pcNext;
      ifid_valid <= 1'b0;
      if (FlushCount != '1) FlushCount <= FlushCount + CNT_WIDTH'(1);
    end else begin
      pc         <= pcNext;
      Inst       <= imem_data;
      PCPlus4    <= pcNext;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        Pipe_stall;
  logic [1:0]  BranchCtl;
  logic        Equal;
  logic [31:0] PCPlus4PlusOff;
  logic        UndefInst;
  logic [31:0] Inst;
  logic [31:0] PCPlus4;
  logic        ifid_valid;
  logic [31:0] EPC;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .Pipe_stall(Pipe_stall), .BranchCtl(BranchCtl), .Equal(Equal),
    .PCPlus4PlusOff(PCPlus4PlusOff), .UndefInst(UndefInst), .Inst(Inst),
    .PCPlus4(PCPlus4), .ifid_valid(ifid_valid), .EPC(EPC),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // Instruction memory: the word is derived from its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 | a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  // ---------------- reference model ----------------
  // This is an architectural view of the fetch stage. The model tracks
  // which PC is fetched next and which instruction sits in decode. It also
  // tracks how many stalls and flushes have happened.
  logic [31:0] m_pc, m_inst, m_pcp4, m_epc;
  logic        m_valid;
  int          m_stalls, m_flushes;

  task automatic model_step();
    bit br;
    br = (BranchCtl == 2'b01 && Equal) || (BranchCtl == 2'b10 && !Equal);
    if (rst) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
      m_epc = 32'h0; m_stalls = 0; m_flushes = 0;
    end else if (UndefInst && m_valid) begin
      m_epc = m_pcp4 - 32'd4;
      m_pc = 32'h80; m_inst = 32'h0; m_valid = 1'b0;
      m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
    end else if (Pipe_stall) begin
      m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
    end else if (br) begin
      m_pcp4 = m_pc + 32'd4;
      m_pc = PCPlus4PlusOff; m_inst = 32'h0; m_valid = 1'b0;
      m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
    end else begin
      m_inst = mem_word(m_pc);
      m_pcp4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply one clock edge with the inputs currently driven. The model sees
  // the same inputs. Outputs are observed 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; Pipe_stall = 1'b0; BranchCtl = 2'b00; Equal = 1'b0;
    PCPlus4PlusOff = 32'h0; UndefInst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 32'h0); end
    checks++; if (Inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected %h", Inst, 32'h0); end
    checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcp4: got %h expected %h", PCPlus4, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifid_valid); end
    checks++; if (EPC !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 0", EPC); end
    checks++; if (StallCount !== 16'h0 || FlushCount !== 16'h0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", StallCount, FlushCount); end
  endtask

  task automatic test_free_run();
    rst = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL run_addr0: got %h expected 0", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL run_addr4: got %h expected 4", imem_addr); end
    checks++; if (Inst !== 32'h2000_0000 || PCPlus4 !== 32'h4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL run_ifid1: got %h/%h/%b expected 20000000/4/1", Inst, PCPlus4, ifid_valid); end
    tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL run_addr8: got %h expected 8", imem_addr); end
    checks++; if (Inst !== 32'h2000_0004 || PCPlus4 !== 32'h8) begin errors++; $display("FAIL run_ifid2: got %h/%h expected 20000004/8", Inst, PCPlus4); end
  endtask

  task automatic test_stall();
    Pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h8 || Inst !== 32'h2000_0004 || PCPlus4 !== 32'h8) begin errors++; $display("FAIL stall_hold%0d: got %h/%h/%h expected 8/20000004/8", i, imem_addr, Inst, PCPlus4); end
    end
    checks++; if (StallCount !== 16'd3) begin errors++; $display("FAIL stall_count: got %0d expected 3", StallCount); end
    Pipe_stall = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'hC || Inst !== 32'h2000_0008 || PCPlus4 !== 32'hC) begin errors++; $display("FAIL stall_resume: got %h/%h/%h expected c/20000008/c", imem_addr, Inst, PCPlus4); end
  endtask

  task automatic test_beq();
    BranchCtl = 2'b01; Equal = 1'b1; PCPlus4PlusOff = 32'h40;
    tick();
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL beq_target: got %h expected 40", imem_addr); end
    checks++; if (Inst !== 32'h0 || ifid_valid !== 1'b0 || PCPlus4 !== 32'h10) begin errors++; $display("FAIL beq_flush: got %h/%b/%h expected 0/0/10", Inst, ifid_valid, PCPlus4); end
    checks++; if (FlushCount !== 16'd1) begin errors++; $display("FAIL beq_flushcount: got %0d expected 1", FlushCount); end
    Equal = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h44 || Inst !== 32'h2000_0040 || ifid_valid !== 1'b1 || FlushCount !== 16'd1) begin errors++; $display("FAIL beq_fallthrough: got %h/%h/%b/%0d expected 44/20000040/1/1", imem_addr, Inst, ifid_valid, FlushCount); end
  endtask

  task automatic test_bne_stall();
    BranchCtl = 2'b10; Equal = 1'b0; PCPlus4PlusOff = 32'h100; Pipe_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h44 || FlushCount !== 16'd1 || ifid_valid !== 1'b1) begin errors++; $display("FAIL bne_stalled%0d: got %h/%0d/%b expected 44/1/1", i, imem_addr, FlushCount, ifid_valid); end
    end
    Pipe_stall = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h100 || ifid_valid !== 1'b0 || FlushCount !== 16'd2 || StallCount !== 16'd5) begin errors++; $display("FAIL bne_redirect: got %h/%b/%0d/%0d expected 100/0/2/5", imem_addr, ifid_valid, FlushCount, StallCount); end
    BranchCtl = 2'b00;
  endtask

  task automatic test_trap();
    BranchCtl = 2'b01; Equal = 1'b1; PCPlus4PlusOff = 32'h20;
    tick();
    BranchCtl = 2'b00;
    tick();
    checks++; if (PCPlus4 !== 32'h24 || ifid_valid !== 1'b1) begin errors++; $display("FAIL trap_setup: got %h/%b expected 24/1", PCPlus4, ifid_valid); end
    UndefInst = 1'b1; Pipe_stall = 1'b1;
    tick();
    checks++; if (EPC !== 32'h20) begin errors++; $display("FAIL trap_epc: got %h expected 20", EPC); end
    checks++; if (imem_addr !== 32'h80 || Inst !== 32'h0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL trap_redirect: got %h/%h/%b expected 80/0/0", imem_addr, Inst, ifid_valid); end
    checks++; if (FlushCount !== 16'd4 || StallCount !== 16'd5) begin errors++; $display("FAIL trap_counts: got %0d/%0d expected 4/5", FlushCount, StallCount); end
    Pipe_stall = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h84 || EPC !== 32'h20 || FlushCount !== 16'd4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL trap_bubble_ignored: got %h/%h/%0d/%b expected 84/20/4/1", imem_addr, EPC, FlushCount, ifid_valid); end
    UndefInst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 49) == 0);
      Pipe_stall     = ($urandom_range(0, 3) == 0);
      UndefInst      = ($urandom_range(0, 7) == 0);
      BranchCtl      = 2'($urandom_range(0, 3));
      Equal          = 1'($urandom_range(0, 1));
      PCPlus4PlusOff = $urandom;
      tick();
      checks++;
      if (imem_addr !== m_pc || Inst !== m_inst || PCPlus4 !== m_pcp4 || ifid_valid !== m_valid ||
          EPC !== m_epc || StallCount !== 16'(m_stalls) || FlushCount !== 16'(m_flushes)) begin
        errors++;
        $display("FAIL random%0d: got pc=%h inst=%h p4=%h v=%b epc=%h sc=%0d fc=%0d expected pc=%h inst=%h p4=%h v=%b epc=%h sc=%0d fc=%0d",
                 i, imem_addr, Inst, PCPlus4, ifid_valid, EPC, StallCount, FlushCount,
                 m_pc, m_inst, m_pcp4, m_valid, m_epc, m_stalls, m_flushes);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_saturate();
    BranchCtl = 2'b01; Equal = 1'b1; PCPlus4PlusOff = 32'hFFFF_FFFC;
    tick();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h expected fffffffc", imem_addr); end
    BranchCtl = 2'b00;
    tick();
    checks++; if (imem_addr !== 32'h0 || PCPlus4 !== 32'h0 || Inst !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h/%h/%h expected 0/0/fffffffc", imem_addr, PCPlus4, Inst); end
    Pipe_stall = 1'b1;
    for (int i = 0; i < 65536 + 5; i++) tick();
    checks++; if (StallCount !== 16'hFFFF || StallCount !== 16'(m_stalls)) begin errors++; $display("FAIL stall_saturate: got %h expected ffff", StallCount); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL sat_hold_pc: got %h expected 0", imem_addr); end
    rst = 1'b1;
    tick();
    checks++;
    if (imem_addr !== 32'h0 || Inst !== 32'h0 || PCPlus4 !== 32'h0 || ifid_valid !== 1'b0 ||
        EPC !== 32'h0 || StallCount !== 16'h0 || FlushCount !== 16'h0) begin
      errors++;
      $display("FAIL reset_midstall: got pc=%h inst=%h p4=%h v=%b epc=%h sc=%0d fc=%0d expected all zero",
               imem_addr, Inst, PCPlus4, ifid_valid, EPC, StallCount, FlushCount);
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_beq();
    test_bne_stall();
    test_trap();
    test_random();
    test_wrap_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
